// File: rtl/clk_div_pkg.sv
// Shared constants for the clock-divider bank: mode encoding, default
// counter width and the legacy start-delay waveform.
package clk_div_pkg;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam int CW_DEF        = 16;
    localparam int LEGACY_PERIOD = 8192;
    localparam int LEGACY_THRESH = 4096;

endpackage

// File: rtl/clk_div_chan.sv
// One programmable clock-enable / waveform channel.
// Outputs reflect the pre-increment count, so they lag cnt by one edge.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CW         = CW_DEF,
    parameter int DEF_PERIOD = LEGACY_PERIOD,
    parameter int DEF_THRESH = LEGACY_THRESH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic          mode,
    input  logic [CW-1:0] period,
    input  logic [CW-1:0] thresh,
    output logic          wave,
    output logic          tick,
    output logic          done
);

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);
    localparam logic [CW-1:0] DEF_T = CW'(DEF_THRESH);

    logic [CW-1:0] cnt;
    logic [CW-1:0] period_r;
    logic [CW-1:0] thresh_r;
    logic          mode_r;
    logic          term;

    // Terminal count; only meaningful when period_r is non-zero.
    assign term = (cnt == period_r - ONE);

    // Channel state: reset > load > disabled > count > hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            period_r <= DEF_P;
            thresh_r <= DEF_T;
            mode_r   <= MODE_FREE;
            wave     <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
        end else if (load) begin
            // Restart without a tick even if the old count was terminal.
            period_r <= period;
            thresh_r <= thresh;
            mode_r   <= mode;
            cnt      <= '0;
            wave     <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
        end else if (period_r == '0) begin
            cnt  <= '0;
            wave <= 1'b0;
            tick <= 1'b0;
            done <= 1'b0;
        end else if (en) begin
            wave <= (cnt >= thresh_r);
            if (done) begin
                // One-shot finished: park on the terminal count.
                tick <= 1'b0;
            end else if (term) begin
                tick <= 1'b1;
                if (mode_r == MODE_ONESHOT) done <= 1'b1;
                else                        cnt  <= '0;
            end else begin
                cnt  <= cnt + ONE;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock-divider channels. With reset defaults each
// channel reproduces the legacy start-delay waveform (4096 low, 4096 high).
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CW         = CW_DEF,
    parameter int DEF_PERIOD = LEGACY_PERIOD,
    parameter int DEF_THRESH = LEGACY_THRESH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    en_i,
    input  logic [NCH-1:0]    load_i,
    input  logic [NCH-1:0]    mode_i,
    input  logic [NCH*CW-1:0] period_i,
    input  logic [NCH*CW-1:0] thresh_i,
    output logic [NCH-1:0]    wave_o,
    output logic [NCH-1:0]    tick_o,
    output logic [NCH-1:0]    done_o
);

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        clk_div_chan #(
            .CW         (CW),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_THRESH (DEF_THRESH)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en_i[k]),
            .load   (load_i[k]),
            .mode   (mode_i[k]),
            .period (period_i[k*CW +: CW]),
            .thresh (thresh_i[k*CW +: CW]),
            .wave   (wave_o[k]),
            .tick   (tick_o[k]),
            .done   (done_o[k])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank. The reference model tracks, per
// channel, how many count edges have elapsed since the last load/reset and
// derives the expected outputs arithmetically from that number.
module tb_clk_div_bank;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    en_i, load_i, mode_i;
    logic [NCH*CW-1:0] period_i, thresh_i;
    logic [NCH-1:0]    wave_o, tick_o, done_o;

    clk_div_bank #(.NCH(NCH), .CW(CW), .DEF_PERIOD(8192), .DEF_THRESH(4096)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .load_i(load_i), .mode_i(mode_i),
        .period_i(period_i), .thresh_i(thresh_i),
        .wave_o(wave_o), .tick_o(tick_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: count edges since load, config, and whether last edge counted.
    int mn[NCH], mp[NCH], mt[NCH];
    bit mm[NCH], mlast[NCH];
    logic [NCH-1:0] ew, et, ed;

    // Advance one clock: update the model on the edge, settle on negedge.
    task automatic edge_step();
        @(posedge clk);
        for (int k = 0; k < NCH; k++) begin
            if (!rst_n) begin
                mn[k] = 0; mp[k] = 8192; mt[k] = 4096; mm[k] = 1'b0; mlast[k] = 1'b0;
            end else if (load_i[k]) begin
                mn[k] = 0; mlast[k] = 1'b0;
                mp[k] = int'(period_i[k*CW +: CW]);
                mt[k] = int'(thresh_i[k*CW +: CW]);
                mm[k] = mode_i[k];
            end else if (en_i[k]) begin
                if (mp[k] != 0) mn[k]++;
                mlast[k] = 1'b1;
            end else begin
                mlast[k] = 1'b0;
            end
        end
        @(negedge clk);
        for (int k = 0; k < NCH; k++) begin
            if (mp[k] == 0 || mn[k] == 0) begin
                ew[k] = 1'b0; et[k] = 1'b0; ed[k] = 1'b0;
            end else if (!mm[k]) begin
                ew[k] = ((mn[k] - 1) % mp[k]) >= mt[k];
                et[k] = mlast[k] && (mn[k] % mp[k] == 0);
                ed[k] = 1'b0;
            end else begin
                ew[k] = (((mn[k] - 1) < (mp[k] - 1)) ? (mn[k] - 1) : (mp[k] - 1)) >= mt[k];
                et[k] = mlast[k] && (mn[k] == mp[k]);
                ed[k] = (mn[k] >= mp[k]);
            end
        end
    endtask

    task automatic cfg(input int k, input int p, input int t, input bit m);
        period_i[k*CW +: CW] = CW'(p);
        thresh_i[k*CW +: CW] = CW'(t);
        mode_i[k]            = m;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_i = '0; load_i = '0; mode_i = '0; period_i = '0; thresh_i = '0;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            n_cmp++;
            if ({wave_o, tick_o, done_o} !== 12'b0) begin
                n_err++;
                $display("FAIL reset: got w=%b t=%b d=%b want all 0", wave_o, tick_o, done_o);
            end
        end
    endtask

    task automatic test_legacy();
        rst_n = 1'b1; en_i = '1;
        for (int i = 1; i <= 8200; i++) begin
            edge_step();
            n_cmp++;
            if ({wave_o, tick_o, done_o} !== {ew, et, ed}) begin
                n_err++;
                $display("FAIL legacy_model E%0d: got w=%b t=%b d=%b want w=%b t=%b d=%b",
                         i, wave_o, tick_o, done_o, ew, et, ed);
            end
            n_cmp++;
            if (wave_o[0] !== (i >= 4097 && i <= 8192) || tick_o[0] !== (i == 8192)) begin
                n_err++;
                $display("FAIL legacy_ch0 E%0d: got w=%b t=%b want w=%b t=%b",
                         i, wave_o[0], tick_o[0], (i >= 4097 && i <= 8192), (i == 8192));
            end
        end
    endtask

    task automatic test_freerun();
        cfg(0, 4, 2, 1'b0);
        load_i = 4'b0001;
        edge_step();
        load_i = '0;
        for (int i = 1; i <= 12; i++) begin
            edge_step();
            n_cmp++;
            if (wave_o[0] !== ((i - 1) % 4 >= 2) || tick_o[0] !== (i % 4 == 0) || done_o[0] !== 1'b0) begin
                n_err++;
                $display("FAIL freerun E%0d: got w=%b t=%b d=%b want w=%b t=%b d=0",
                         i, wave_o[0], tick_o[0], done_o[0], ((i - 1) % 4 >= 2), (i % 4 == 0));
            end
        end
    endtask

    task automatic test_oneshot();
        cfg(1, 10, 9, 1'b1);
        load_i = 4'b0010;
        edge_step();
        load_i = '0;
        for (int i = 1; i <= 110; i++) begin
            edge_step();
            n_cmp++;
            if (wave_o[1] !== (i >= 10) || tick_o[1] !== (i == 10) || done_o[1] !== (i >= 10)) begin
                n_err++;
                $display("FAIL oneshot E%0d: got w=%b t=%b d=%b want w=%b t=%b d=%b",
                         i, wave_o[1], tick_o[1], done_o[1], (i >= 10), (i == 10), (i >= 10));
            end
        end
        load_i = 4'b0010;
        edge_step();
        load_i = '0;
        n_cmp++;
        if ({wave_o[1], tick_o[1], done_o[1]} !== 3'b000) begin
            n_err++;
            $display("FAIL oneshot_reload: got w=%b t=%b d=%b want 000", wave_o[1], tick_o[1], done_o[1]);
        end
    endtask

    task automatic test_gating();
        cfg(2, 6, 3, 1'b0);
        load_i = 4'b0100;
        edge_step();
        load_i = '0;
        edge_step(); edge_step();            // cnt now 2
        en_i[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_step();
            n_cmp++;
            if (wave_o[2] !== 1'b0 || tick_o[2] !== 1'b0 || {wave_o, tick_o, done_o} !== {ew, et, ed}) begin
                n_err++;
                $display("FAIL gating_hold %0d: got w=%b t=%b d=%b want w=%b t=%b d=%b",
                         i, wave_o, tick_o, done_o, ew, et, ed);
            end
        end
        en_i[2] = 1'b1;
        for (int i = 3; i <= 14; i++) begin
            edge_step();
            n_cmp++;
            if (wave_o[2] !== ((i - 1) % 6 >= 3) || tick_o[2] !== (i % 6 == 0)) begin
                n_err++;
                $display("FAIL gating_resume n%0d: got w=%b t=%b want w=%b t=%b",
                         i, wave_o[2], tick_o[2], ((i - 1) % 6 >= 3), (i % 6 == 0));
            end
        end
        // Load on the terminal edge must suppress the tick.
        cfg(3, 4, 1, 1'b0);
        load_i = 4'b1000;
        edge_step();
        load_i = '0;
        edge_step(); edge_step(); edge_step(); // cnt now 3 = period-1
        load_i = 4'b1000;
        edge_step();
        load_i = '0;
        n_cmp++;
        if ({wave_o[3], tick_o[3], done_o[3]} !== 3'b000) begin
            n_err++;
            $display("FAIL load_priority: got w=%b t=%b d=%b want 000", wave_o[3], tick_o[3], done_o[3]);
        end
        for (int i = 1; i <= 8; i++) begin
            edge_step();
            n_cmp++;
            if (tick_o[3] !== (i % 4 == 0) || {wave_o, tick_o, done_o} !== {ew, et, ed}) begin
                n_err++;
                $display("FAIL load_restart E%0d: got t=%b want t=%b", i, tick_o[3], (i % 4 == 0));
            end
        end
    endtask

    task automatic test_corners();
        cfg(0, 0, 0, 1'b0);
        cfg(1, 5, 7, 1'b0);
        cfg(2, 6, 0, 1'b0);
        cfg(3, 0, 3, 1'b1);
        load_i = '1;
        edge_step();
        load_i = '0;
        for (int i = 1; i <= 50; i++) begin
            edge_step();
            n_cmp++;
            if ({wave_o[0], tick_o[0], done_o[0], wave_o[3], tick_o[3], done_o[3]} !== 6'b0 ||
                wave_o[1] !== 1'b0 || tick_o[1] !== (i % 5 == 0) || wave_o[2] !== 1'b1) begin
                n_err++;
                $display("FAIL corners E%0d: got w=%b t=%b d=%b want w=%b t=%b d=%b",
                         i, wave_o, tick_o, done_o, ew, et, ed);
            end
        end
    endtask

    task automatic test_independence();
        int per[NCH];
        int last[NCH];
        per = '{3, 5, 7, 11};
        for (int k = 0; k < NCH; k++) begin
            cfg(k, per[k], 1, 1'b0);
            last[k] = 0;
        end
        load_i = '1;
        edge_step();
        load_i = '0;
        for (int i = 1; i <= 80; i++) begin
            edge_step();
            for (int k = 0; k < NCH; k++) begin
                n_cmp++;
                if (tick_o[k] !== (i % per[k] == 0)) begin
                    n_err++;
                    $display("FAIL indep ch%0d E%0d: got t=%b want t=%b", k, i, tick_o[k], (i % per[k] == 0));
                end
                if (tick_o[k] === 1'b1) begin
                    n_cmp++;
                    if (i - last[k] != per[k]) begin
                        n_err++;
                        $display("FAIL indep_spacing ch%0d: got %0d want %0d", k, i - last[k], per[k]);
                    end
                    last[k] = i;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        edge_step();
        n_cmp++;
        if ({wave_o, tick_o, done_o} !== 12'b0) begin
            n_err++;
            $display("FAIL reset_mid: got w=%b t=%b d=%b want all 0", wave_o, tick_o, done_o);
        end
        rst_n = 1'b1; en_i = '1;
        for (int i = 1; i <= 4100; i++) begin
            edge_step();
            n_cmp++;
            if (wave_o !== ((i >= 4097) ? 4'hF : 4'h0) || {wave_o, tick_o, done_o} !== {ew, et, ed}) begin
                n_err++;
                $display("FAIL reset_defaults E%0d: got w=%b t=%b d=%b want w=%b t=%b d=%b",
                         i, wave_o, tick_o, done_o, ew, et, ed);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NCH; k++) begin
                en_i[k]   = ($urandom_range(0, 3) != 0);
                load_i[k] = ($urandom_range(0, 19) == 0);
                if (load_i[k])
                    cfg(k, $urandom_range(0, 12), $urandom_range(0, 14), 1'($urandom_range(0, 1)));
            end
            edge_step();
            n_cmp++;
            if ({wave_o, tick_o, done_o} !== {ew, et, ed}) begin
                n_err++;
                $display("FAIL random %0d: got w=%b t=%b d=%b want w=%b t=%b d=%b",
                         i, wave_o, tick_o, done_o, ew, et, ed);
            end
        end
        load_i = '0;
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_freerun();
        test_oneshot();
        test_gating();
        test_corners();
        test_independence();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised bank of NCH independent programmable clock-enable and waveform generators.
- Each channel produces three outputs: a square/PWM level, a one-cycle wrap tick, and an optional one-shot "start" level.
- It is the general successor to the fixed 13-bit start-delay counter. With reset defaults it reproduces that legacy waveform: low for 4096 cycles, then high for 4096, period 8192.
- Feeds the game/sequencer logic with tempo ticks and power-up start gating.

Parameters:
- NCH, 4, number of independent channels.
- CW, 16, counter/period/threshold width per channel.
- DEF_PERIOD, 8192, per-channel period loaded at reset.
- DEF_THRESH, 4096, per-channel threshold loaded at reset.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- en_i  in  NCH  per-channel count enable.
- load_i  in  NCH  per-channel load strobe; latches configuration and restarts that channel.
- mode_i  in  NCH  per-channel mode sampled on load: 0 = free-run, 1 = one-shot.
- period_i  in  NCH*CW  packed periods; channel k uses bits [k*CW +: CW].
- thresh_i  in  NCH*CW  packed thresholds; same packing as period_i.
- wave_o  out  NCH  registered level output.
- tick_o  out  NCH  registered one-cycle wrap/terminal pulse.
- done_o  out  NCH  registered one-shot completion level.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n. Every channel is independent.
- Per-channel state: cnt (CW bits), period_r, thresh_r, mode_r, done_r.
- Reset (rst_n=0 at an edge):
  - cnt=0, period_r=DEF_PERIOD, thresh_r=DEF_THRESH, mode_r=0.
  - wave_o=0, tick_o=0, done_o=0.
- Load (load_i[k]=1 at an edge; has priority over en_i):
  - period_r/thresh_r/mode_r take the port values.
  - cnt=0, done=0, wave=0, tick=0.
  - No tick is produced on a load edge, even if cnt was terminal.
- Count edge (en_i[k]=1, no load, period_r != 0):
  - wave <= (cnt >= thresh_r), i.e. outputs reflect the pre-increment count and lag cnt by one edge.
  - Free-run:
    - cnt == period_r-1: cnt<=0, tick<=1.
    - Otherwise cnt<=cnt+1, tick<=0.
  - One-shot:
    - cnt == period_r-1 and done=0: tick<=1, done<=1, cnt holds.
    - Once done=1: cnt holds, tick<=0, wave and done stay high until the next load or reset.
- Hold (en_i[k]=0, no load): cnt, wave and done hold; tick<=0.
- period_r == 0: channel disabled. cnt held at 0; wave, tick and done all 0.
- thresh_r >= period_r: wave never rises; tick and done still operate normally.
- thresh_r == 0: wave is high on every count edge.
- Free-run duty: low thresh_r edges, high period_r-thresh_r edges, exact period period_r.
- Counter arithmetic: unsigned, CW bits. cnt never exceeds period_r-1, so no overflow is possible.

Decomposition:
- Package clk_div_pkg holds:
  - MODE_FREE = 1'b0, MODE_ONESHOT = 1'b1.
  - Default CW.
  - Legacy constants LEGACY_PERIOD = 8192 and LEGACY_THRESH = 4096.
- Sub-module clk_div_chan implements one channel: scalar ports, CW/DEF parameters.
- clk_div_bank instantiates clk_div_chan NCH times in a generate loop and only slices the packed buses.

Test Plan:
1. Legacy default: reset, then en_i=all 1, no load.
   -> Edge E0 is the last reset edge. wave_o[0] is first high after E4097 and stays high for 4096 edges.
   -> tick_o[0] pulses once every 8192 edges, first after E8192.
2. Free-run: load period=4, thresh=2, mode=0 at E0, en=1.
   -> wave 0,0,1,1 repeating after E1..E4.
   -> tick high only after E4, E8, E12.
   -> done stays 0.
3. One-shot: load period=10, thresh=9, mode=1.
   -> wave, tick and done are all first high after E10. tick lasts exactly 1 cycle.
   -> wave and done stay high for 100 further cycles.
   -> A reload clears all three on the load edge.
4. Gating and priority:
   -> Deassert en at cnt=2 for 5 cycles: outputs frozen, no tick, and the phase resumes exactly.
   -> Assert load on the same edge where cnt==period-1: no tick, cnt=0.
5. Corner configs:
   -> period=0: all outputs 0 for 50 cycles.
   -> period=5, thresh=7: wave stays 0, tick every 5 edges.
   -> thresh=0: wave constantly 1.
6. Channel independence and reset mid-operation:
   -> Run four channels with different periods (3, 5, 7, 11) and check each tick spacing.
   -> Pulse rst_n low mid-count: all outputs 0 after that edge, and defaults are restored.
